serial_word_sender: RTL and testbench
=====================================

# serial_word_sender

Parallel-to-serial front end that feeds the team's shift register. Accepts an N-bit word over a valid/ready handshake, then drives its bits one per clock on `I_out` in the order selected by `msb_first`. Holds the matching `dir_out` level for the whole word, so the downstream register shifts consistently and `D` holds the complete word after the last bit. Supports gap-free back-to-back words.

## Interface
- `N`, default 8: data word width in bits; legal range 2..32.
- `IDLE_BIT`, default 0: level driven on `I_out` when no word is in flight.

- `clk`  input  1  rising-edge clock.
- `reset`  input  1  synchronous, active-low reset; sampled on the rising edge of `clk`.
- `data_in`  input  N  word to transmit; sampled only on an accepted handshake.
- `valid_in`  input  1  `data_in` and `msb_first` are valid.
- `msb_first`  input  1  1 = send bit N-1 first; 0 = send bit 0 first; sampled with `data_in`.
- `ready_out`  output  1  sender can accept a word this cycle.
- `I_out`  output  1  serial bit to the shift register's `I`.
- `dir_out`  output  1  latched `msb_first` for the word in flight; drives the shift register's `direction`.
- `busy`  output  1  a word or parity bit is being driven on `I_out`.
- `last_out`  output  1  high during the final serial bit of a word.

## Operation
- States:
  - IDLE: `ready_out`=1, `busy`=0, `I_out`=`IDLE_BIT`.
  - SEND: bit counter runs 0..N-1.
  - PARITY: present only with the parity macro.
- Accept: `valid_in`=1 and `ready_out`=1 at a rising edge. The word goes into an N-bit hold register, `msb_first` goes into `dir_out`, the counter clears to 0, and the state moves to SEND.
- SEND, count k:
  - `I_out` = `data[N-1-k]` if latched `msb_first`, else `data[k]`.
  - The counter increments every cycle. No stall; the downstream register has no enable.
- Last data bit (k = N-1), no parity:
  - `last_out`=1 and `ready_out`=1.
  - Accept in this cycle: go to SEND with the new word, count 0. No idle gap.
  - No accept: go to IDLE.
- `dir_out` holds its value until the next accept. It is not cleared in IDLE.
- `valid_in` while `ready_out`=0 is ignored. The producer must hold `valid_in` and `data_in` until it sees `ready_out`=1.
- The counter is `$clog2(N+1)` bits wide and never wraps past N-1 in SEND.

## Timing
- Reset values, one cycle after a low `reset` at an edge:
  - `ready_out`=1, `busy`=0, `last_out`=0, `I_out`=`IDLE_BIT`, `dir_out`=0.
  - State IDLE, counter 0, hold register 0.
- All outputs are registered. None depends combinationally on `valid_in` except through the next edge.
- Latency: first serial bit appears on `I_out` in the cycle after the accept edge. A word occupies exactly N cycles (N+1 with parity).
- Throughput: one word per N (or N+1) cycles when `valid_in` is held high continuously.
- Reset mid-word: the word is discarded, no further bits are driven, and reset values apply from the next cycle.
- Reset has priority over a simultaneous handshake; the word is not accepted.

## Configuration
- Macro `SERIAL_WORD_SENDER_PARITY_EN`.
- Defined:
  - After bit N-1 the state enters PARITY for one cycle with `I_out` = XOR of the latched word (even parity).
  - `last_out` and `ready_out` move from the last data bit to the PARITY cycle.
  - A word takes N+1 cycles.
- Undefined: PARITY state and parity logic are absent; behaviour is as in Operation.

## Test plan
- Reset: hold `reset`=0 for 2 edges with `valid_in`=1 -> `ready_out`=1, `I_out`=0, `busy`=0, no word accepted.
- LSB-first, N=8: send 8'b1011_0010 with `msb_first`=0.
  - `I_out` over 8 cycles = 0,1,0,0,1,1,0,1.
  - `dir_out`=0 throughout; `last_out` high on the 8th cycle only.
  - Downstream register `D` holds the word one edge later.
- MSB-first: send 8'hA5 with `msb_first`=1 -> `I_out` = 1,0,1,0,0,1,0,1; `dir_out`=1 throughout.
- Back-to-back: `valid_in` held high with 8'hFF then 8'h00 -> 8 ones immediately followed by 8 zeros. No `IDLE_BIT` cycle between them; `ready_out` high only on each 8th bit.
- Reset mid-word: assert `reset`=0 during bit 3 of 8'hF0 -> next cycle `I_out`=`IDLE_BIT`, `busy`=0, `last_out` never pulses.
- Parity build: with `SERIAL_WORD_SENDER_PARITY_EN` defined, send 8'h07.
  - 9 serial bits; 9th bit = 1.
  - `last_out` and `ready_out` high on the 9th cycle only.

Source files
------------

// File: rtl/serial_word_sender.sv
// Parallel-to-serial sender: one N-bit word per handshake, one bit per clock.
// Optional even-parity trailer bit with SERIAL_WORD_SENDER_PARITY_EN.
module serial_word_sender #(
    parameter int N        = 8,
    parameter bit IDLE_BIT = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] data_in,
    input  logic         valid_in,
    input  logic         msb_first,
    output logic         ready_out,
    output logic         I_out,
    output logic         dir_out,
    output logic         busy,
    output logic         last_out
);

    localparam int CW = $clog2(N + 1);

`ifdef SERIAL_WORD_SENDER_PARITY_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND   = 2'd1,
        PARITY = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1
    } state_t;
`endif

    state_t          state;
    state_t          state_n;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_n;
    logic [N-1:0]    hold;
    logic [N-1:0]    hold_n;
    logic            dir_n;
    logic            accept;
    logic            do_load;
    logic            last_bit;
    logic [CW-1:0]   sh;
    logic [N-1:0]    shifted;
    logic            busy_n;
    logic            final_n;
    logic            ready_n;
    logic            i_n;

    assign accept   = valid_in && ready_out;
    assign last_bit = (cnt == CW'(N - 1));

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        hold_n  = hold;
        dir_n   = dir_out;
        do_load = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) do_load = 1'b1;
            end
            SEND: begin
                if (!last_bit) begin
                    cnt_n = cnt + 1'b1;
                end else begin
`ifdef SERIAL_WORD_SENDER_PARITY_EN
                    state_n = PARITY;
`else
                    if (accept) do_load = 1'b1;
                    else        state_n = IDLE;
`endif
                end
            end
`ifdef SERIAL_WORD_SENDER_PARITY_EN
            PARITY: begin
                if (accept) do_load = 1'b1;
                else        state_n = IDLE;
            end
`endif
            default: state_n = IDLE;
        endcase
        if (do_load) begin
            state_n = SEND;
            cnt_n   = '0;
            hold_n  = data_in;
            dir_n   = msb_first;
        end
    end

    // Outputs are computed from next-state values so they can be registered.
    always_comb begin
        sh      = dir_n ? (CW'(N - 1) - cnt_n) : cnt_n;
        shifted = hold_n >> sh;
        busy_n  = (state_n != IDLE);
`ifdef SERIAL_WORD_SENDER_PARITY_EN
        final_n = (state_n == PARITY);
`else
        final_n = (state_n == SEND) && (cnt_n == CW'(N - 1));
`endif
        ready_n = !busy_n || final_n;
        i_n     = IDLE_BIT;
        if (state_n == SEND) i_n = shifted[0];
`ifdef SERIAL_WORD_SENDER_PARITY_EN
        if (state_n == PARITY) i_n = ^hold_n;
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            hold      <= '0;
            dir_out   <= 1'b0;
            ready_out <= 1'b1;
            busy      <= 1'b0;
            last_out  <= 1'b0;
            I_out     <= IDLE_BIT;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            hold      <= hold_n;
            dir_out   <= dir_n;
            ready_out <= ready_n;
            busy      <= busy_n;
            last_out  <= final_n;
            I_out     <= i_n;
        end
    end

endmodule

// File: tb/tb_serial_word_sender.sv
// Directed bench for serial_word_sender with a downstream shift-register model.
// Parity expectations apply when SERIAL_WORD_SENDER_PARITY_EN is defined.
module tb_serial_word_sender;

    localparam int N = 8;
`ifdef SERIAL_WORD_SENDER_PARITY_EN
    localparam int LASTK = N;
`else
    localparam int LASTK = N - 1;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] data_in;
    logic         valid_in;
    logic         msb_first;
    logic         ready_out;
    logic         I_out;
    logic         dir_out;
    logic         busy;
    logic         last_out;
    logic [N-1:0] d_reg = '0;

    int vectors = 0;
    int errors  = 0;

    serial_word_sender #(.N(N), .IDLE_BIT(1'b0)) dut (
        .clk       (clk),
        .reset     (reset),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .msb_first (msb_first),
        .ready_out (ready_out),
        .I_out     (I_out),
        .dir_out   (dir_out),
        .busy      (busy),
        .last_out  (last_out)
    );

    always #5 clk = ~clk;

    // Downstream shift register: left shift when direction=1, right otherwise.
    always @(posedge clk)
        d_reg <= dir_out ? {d_reg[N-2:0], I_out} : {I_out, d_reg[N-1:1]};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // seq holds the expected serial bits, first bit in seq[N-1].
    task automatic send_word(input logic [N-1:0] w, input logic msb,
                             input logic [N-1:0] seq);
        data_in   = w;
        msb_first = msb;
        valid_in  = 1'b1;
        tick();
        valid_in  = 1'b0;
        for (int k = 0; k <= LASTK; k++) begin
            if (k < N) chk("bit", 32'(I_out), 32'(seq[N-1-k]));
            else       chk("parity", 32'(I_out), 32'(^w));
            chk("dir", 32'(dir_out), 32'(msb));
            chk("busy", 32'(busy), 32'd1);
            chk("last", 32'(last_out), 32'(k == LASTK));
            chk("ready", 32'(ready_out), 32'(k == LASTK));
            tick();
            if (k == N - 1) chk("d_reg", 32'(d_reg), 32'(w));
        end
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_I", 32'(I_out), 32'd0);
        chk("idle_dir_kept", 32'(dir_out), 32'(msb));
    endtask

    initial begin
        reset     = 1'b0;
        valid_in  = 1'b1;
        data_in   = 8'hFF;
        msb_first = 1'b1;
        tick();
        tick();
        chk("rst_ready", 32'(ready_out), 32'd1);
        chk("rst_I", 32'(I_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_last", 32'(last_out), 32'd0);
        chk("rst_dir", 32'(dir_out), 32'd0);
        valid_in = 1'b0;
        reset    = 1'b1;
        tick();
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_I", 32'(I_out), 32'd0);

        send_word(8'b1011_0010, 1'b0, 8'b0100_1101);
        send_word(8'hA5, 1'b1, 8'b1010_0101);

        // Back-to-back: FF then 00, valid held high throughout
        data_in   = 8'hFF;
        msb_first = 1'b1;
        valid_in  = 1'b1;
        tick();
        for (int k = 0; k <= LASTK; k++) begin
            if (k < N) chk("b2b_ones", 32'(I_out), 32'd1);
            chk("b2b_ready0", 32'(ready_out), 32'(k == LASTK));
            chk("b2b_busy0", 32'(busy), 32'd1);
            if (k == LASTK) data_in = 8'h00;
            tick();
        end
        for (int k = 0; k <= LASTK; k++) begin
            if (k < N) chk("b2b_zeros", 32'(I_out), 32'd0);
            chk("b2b_ready1", 32'(ready_out), 32'(k == LASTK));
            chk("b2b_busy1", 32'(busy), 32'd1);
            chk("b2b_last1", 32'(last_out), 32'(k == LASTK));
            if (k == LASTK) valid_in = 1'b0;
            tick();
        end
        chk("b2b_end_busy", 32'(busy), 32'd0);

        // Reset during bit 3 of F0, LSB first: bits 0,0,0,0,1,1,1,1
        data_in   = 8'hF0;
        msb_first = 1'b0;
        valid_in  = 1'b1;
        tick();
        valid_in  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("mid_bit", 32'(I_out), 32'd0);
            tick();
        end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("mid_I", 32'(I_out), 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_ready", 32'(ready_out), 32'd1);
        chk("mid_dir", 32'(dir_out), 32'd0);
        for (int k = 0; k < N; k++) begin
            chk("mid_last", 32'(last_out), 32'd0);
            chk("mid_quiet", 32'(busy), 32'd0);
            tick();
        end

`ifdef SERIAL_WORD_SENDER_PARITY_EN
        send_word(8'h07, 1'b0, 8'b1110_0000);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
